dither_rgb: RTL and testbench

DITHER_RGB -- requirements
Module: dither_rgb

---
 rtl/dither_pkg.sv | 28 ++
 rtl/dither_rgb_if.sv | 31 +++
 rtl/dither_quant.sv | 92 +++++++++
 rtl/dither_rgb.sv | 93 +++++++++
 tb/tb_dither_rgb.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dither_pkg.sv
`default_nettype none
// ============================================================================
// Module : dither_pkg
// Brief  : Mode encoding and STEP/HALF/QMAX helpers for the RGB ditherer.
// Rev    : 1.0  initial release
// ============================================================================
package dither_pkg;

  typedef enum logic [1:0] {
    MODE_DIFFUSE = 2'b00,
    MODE_TRUNC   = 2'b01,
    MODE_ROUND   = 2'b10
  } dither_mode_e;

  function automatic int dither_step(input int in_w, input int out_w);
    return 1 << (in_w - out_w);
  endfunction

  function automatic int dither_half(input int in_w, input int out_w);
    return dither_step(in_w, out_w) / 2;
  endfunction

  function automatic int dither_qmax(input int out_w);
    return (1 << out_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dither_rgb_if.sv
`default_nettype none
// ============================================================================
// Module : dither_rgb_if
// Brief  : Pixel stream in/out handshake bundle for dither_rgb.
// Rev    : 1.0  initial release
// ============================================================================
interface dither_rgb_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int NCH   = 3
);
  logic [NCH*IN_W-1:0]  in_pix;
  logic                 in_sol;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [NCH*OUT_W-1:0] out_pix;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_pix, in_sol, in_valid, mode, out_ready,
    input  in_ready, out_pix, out_valid
  );

  modport slave (
    input  in_pix, in_sol, in_valid, mode, out_ready,
    output in_ready, out_pix, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/dither_quant.sv
`default_nettype none
// ============================================================================
// Module : dither_quant
// Brief  : Combinational single-channel quantiser (diffuse / truncate / round).
// Rev    : 1.0  initial release
// ============================================================================
module dither_quant
  import dither_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]               i_in,
  input  logic signed [IN_W-OUT_W+1:0]  i_err,
  input  dither_mode_e                  i_mode,
  input  logic                          i_sol,
  output logic [OUT_W-1:0]              o_q,
  output logic signed [IN_W-OUT_W+1:0]  o_err_next,
  output logic                          o_sat
);
  localparam int S  = IN_W - OUT_W;
  localparam int EW = S + 2;
  localparam int SW = IN_W + 2;

  localparam logic signed [SW-1:0] c_qmax    = SW'(dither_qmax(OUT_W));
  localparam logic signed [SW:0]   c_err_max = (SW+1)'(dither_step(IN_W, OUT_W) - 1);
  localparam logic signed [SW:0]   c_err_min = (SW+1)'(-dither_half(IN_W, OUT_W));

  logic signed [SW-1:0] w_in_ext;
  logic signed [SW-1:0] w_e_ext;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_floor;
  logic signed [SW-1:0] w_qraw;
  logic signed [SW-1:0] w_qs;
  logic signed [SW:0]   w_res;
  logic [OUT_W-1:0]     w_qc;
  logic signed [EW-1:0] w_err_sat;
  logic                 w_clamp;
  logic                 w_esat;

  always_comb begin
    w_in_ext = $signed({2'b00, i_in});
    w_e_ext  = '0;
    if (i_mode == MODE_DIFFUSE && !i_sol) begin
      w_e_ext = SW'(i_err);
    end
    w_sum   = w_in_ext + w_e_ext;
    // Floor division by STEP, then round half up using the top fraction bit.
    w_floor = w_sum >>> S;
    w_qraw  = w_floor + $signed({{(SW-1){1'b0}}, w_sum[S-1]});

    w_clamp = 1'b0;
    if (w_qraw[SW-1]) begin
      w_qc = '0;
    end else if (w_qraw > c_qmax) begin
      w_qc    = c_qmax[OUT_W-1:0];
      w_clamp = 1'b1;
    end else begin
      w_qc = w_qraw[OUT_W-1:0];
    end

    w_qs  = $signed({2'b00, w_qc, {S{1'b0}}});
    w_res = (SW+1)'(w_sum) - (SW+1)'(w_qs);

    w_esat    = 1'b0;
    w_err_sat = w_res[EW-1:0];
    if (w_res > c_err_max) begin
      w_err_sat = c_err_max[EW-1:0];
      w_esat    = 1'b1;
    end else if (w_res < c_err_min) begin
      w_err_sat = c_err_min[EW-1:0];
      w_esat    = 1'b1;
    end

    o_q        = i_in[IN_W-1:S];
    o_err_next = '0;
    o_sat      = 1'b0;
    case (i_mode)
      MODE_DIFFUSE: begin
        o_q        = w_qc;
        o_err_next = w_err_sat;
        o_sat      = w_clamp | w_esat;
      end
      MODE_ROUND: begin
        o_q   = w_qc;
        o_sat = w_clamp;
      end
      default: ;  // truncate, and the reserved encoding behaves as truncate
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/dither_rgb.sv
`default_nettype none
// ============================================================================
// Module : dither_rgb
// Brief  : Multi-channel error-diffusion ditherer with 1-deep output register.
//          Define DITHER_SAT_CNT_EN to add the 16-bit sat_count output.
// Rev    : 1.0  initial release
// ============================================================================
module dither_rgb
  import dither_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int NCH   = 3
) (
  input  logic         clk,
  input  logic         rst,
  dither_rgb_if.slave  bus
`ifdef DITHER_SAT_CNT_EN
  ,
  output logic [15:0]  sat_count
`endif
);
  localparam int EW = IN_W - OUT_W + 2;

  logic [NCH*OUT_W-1:0] w_q;
  logic [NCH*EW-1:0]    w_err_next;
  logic [NCH-1:0]       w_sat;
  logic [NCH*OUT_W-1:0] r_out_pix;
  logic [NCH*EW-1:0]    r_err;
  logic                 r_out_valid;
  logic                 w_in_ready;
  logic                 w_accept;
  dither_mode_e         w_mode;

  assign w_mode     = dither_mode_e'(bus.mode);
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_pix   = r_out_pix;
  assign bus.out_valid = r_out_valid;

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      dither_quant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_quant (
        .i_in       (bus.in_pix[g*IN_W +: IN_W]),
        .i_err      (r_err[g*EW +: EW]),
        .i_mode     (w_mode),
        .i_sol      (bus.in_sol),
        .o_q        (w_q[g*OUT_W +: OUT_W]),
        .o_err_next (w_err_next[g*EW +: EW]),
        .o_sat      (w_sat[g])
      );
    end
  endgenerate

  // Error state advances only with an accepted beat; reset wins over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
      r_err       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pix   <= w_q;
      r_err       <= w_err_next;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DITHER_SAT_CNT_EN
  logic [15:0] r_sat_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (w_accept && (|w_sat) && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  logic w_sat_unused;
  assign w_sat_unused = |w_sat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dither_rgb.sv
`default_nettype none
// ============================================================================
// Module : tb_dither_rgb
// Brief  : Self-checking bench for dither_rgb against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dither_rgb;
  localparam int IN_W  = 8;
  localparam int OUT_W = 4;
  localparam int NCH   = 3;
  localparam int EW    = IN_W - OUT_W + 2;
  localparam int STEP  = 1 << (IN_W - OUT_W);
  localparam int HALF  = STEP / 2;
  localparam int QMAX  = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dither_rgb_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) bus ();
`ifdef DITHER_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  dither_rgb #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef DITHER_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state: pending output beats, per-channel error, saturation count.
  logic [NCH*OUT_W-1:0] m_q[$];
  int                   m_err[NCH];
  int                   m_sat;
  bit                   m_after_rst;

  function automatic void quant_model(input int x, input int e, input int md,
                                      output int q, output int en, output bit sat);
    int sum, fl, r;
    sat = 1'b0;
    if (md == 1 || md == 3) begin
      q  = x / STEP;
      en = 0;
      return;
    end
    sum = (md == 0) ? x + e : x;
    fl  = (sum + 4 * STEP) / STEP - 4;
    r   = sum - fl * STEP;
    q   = fl + ((r >= HALF) ? 1 : 0);
    if (q > QMAX) begin q = QMAX; sat = 1'b1; end
    if (q < 0) q = 0;
    en = (md == 0) ? sum - q * STEP : 0;
    if (en > STEP - 1) begin en = STEP - 1; sat = 1'b1; end
    if (en < -HALF)    begin en = -HALF;    sat = 1'b1; end
  endfunction

  function automatic logic [NCH*EW-1:0] pack_err();
    logic [NCH*EW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*EW +: EW] = m_err[c][EW-1:0];
    return r;
  endfunction

  task automatic cycle(input bit r, input bit iv, input logic [NCH*IN_W-1:0] pix,
                       input bit sol, input logic [1:0] md, input bit ordy);
    bit                   exp_rdy, any_sat, s;
    int                   q, en;
    logic [NCH*OUT_W-1:0] ep;
    @(negedge clk);
    rst          = r;
    bus.in_valid = iv;
    bus.in_pix   = pix;
    bus.in_sol   = sol;
    bus.mode     = md;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (m_q.size() == 0) || ordy;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_pix", 32'(bus.out_pix), 32'(m_q[0]));
    else if (m_after_rst) check("out_pix_rst", 32'(bus.out_pix), 32'd0);
    check("err", 32'(dut.r_err), 32'(pack_err()));
`ifdef DITHER_SAT_CNT_EN
    check("sat_count", 32'(sat_count), 32'(m_sat));
`endif
    if (r) begin
      m_q.delete();
      for (int c = 0; c < NCH; c++) m_err[c] = 0;
      m_sat       = 0;
      m_after_rst = 1'b1;
    end else begin
      if (m_q.size() != 0 && ordy) void'(m_q.pop_front());
      if (iv && exp_rdy) begin
        any_sat = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          quant_model(int'(pix[c*IN_W +: IN_W]), sol ? 0 : m_err[c], int'(md), q, en, s);
          ep[c*OUT_W +: OUT_W] = q[OUT_W-1:0];
          m_err[c] = en;
          any_sat  = any_sat | s;
        end
        m_q.push_back(ep);
        if (any_sat && m_sat < 65535) m_sat++;
        m_after_rst = 1'b0;
      end
    end
  endtask

  function automatic logic [NCH*IN_W-1:0] rand_pix();
    logic [NCH*IN_W-1:0] p;
    for (int c = 0; c < NCH; c++) begin
      case ($urandom_range(0, 7))
        0:       p[c*IN_W +: IN_W] = '0;
        1:       p[c*IN_W +: IN_W] = '1;
        2:       p[c*IN_W +: IN_W] = 8'h08;
        default: p[c*IN_W +: IN_W] = IN_W'($urandom);
      endcase
    end
    return p;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_sol    = 1'b0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) m_err[c] = 0;
    m_sat       = 0;
    m_after_rst = 1'b1;
    repeat (2) @(posedge clk);

    cycle(1, 0, '0, 0, 2'b00, 1);
    cycle(1, 1, 24'h080808, 0, 2'b00, 1);

    // Constant 0x08 diffuse stream: outputs alternate 1,0 with err -8,0.
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 24'h080808, i == 0, 2'b00, 1);
      if (i == 1) begin
        check("d031_q0", 32'(bus.out_pix), 32'h111);
        check("d031_err0", 32'(dut.r_err), 32'h38E38);
      end
      if (i == 2) begin
        check("d031_q1", 32'(bus.out_pix), 32'h000);
        check("d031_err1", 32'(dut.r_err), 32'h0);
      end
    end

    // Start-of-line beat ignores a pending err of -8.
    cycle(0, 1, 24'h080808, 0, 2'b00, 1);
    cycle(0, 1, 24'h080808, 1, 2'b00, 1);
    cycle(0, 0, '0, 0, 2'b00, 1);
    check("d033_sol", 32'(bus.out_pix), 32'h111);

    // Full-scale input clamps q and saturates err.
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 24'hFFFFFF, i == 0, 2'b00, 1);
      if (i == 2) begin
        check("d032_q", 32'(bus.out_pix), 32'hFFF);
        check("d032_err", 32'(dut.r_err), 32'h0F3CF);
      end
    end

    // Output backpressure for 5 cycles with input pending.
    cycle(0, 1, 24'h123456, 0, 2'b00, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, rand_pix(), 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, rand_pix(), 0, 2'b00, 1);

    // Truncate, round and reserved mode.
    cycle(0, 1, 24'h1F1F1F, 0, 2'b01, 1);
    cycle(0, 1, 24'h181818, 0, 2'b10, 1);
    check("d035_trunc", 32'(bus.out_pix), 32'h111);
    cycle(0, 1, 24'hF8F8F8, 0, 2'b10, 1);
    check("d035_round18", 32'(bus.out_pix), 32'h222);
    cycle(0, 1, 24'h1F1F1F, 0, 2'b11, 1);
    check("d035_roundF8", 32'(bus.out_pix), 32'hFFF);
    cycle(0, 0, '0, 0, 2'b00, 1);
    check("d035_rsvd", 32'(bus.out_pix), 32'h111);

    // Reset mid-stream coinciding with an accepted beat.
    cycle(0, 1, 24'h080808, 0, 2'b00, 1);
    cycle(1, 1, 24'h080808, 0, 2'b00, 1);
    cycle(0, 1, 24'h080808, 0, 2'b00, 1);
    check("d036_ov", 32'(bus.out_valid), 32'd0);
    check("d036_err", 32'(dut.r_err), 32'd0);
    cycle(0, 0, '0, 0, 2'b00, 1);
    check("d036_q", 32'(bus.out_pix), 32'h111);

    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rand_pix(),
            $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
    end

    cycle(0, 0, '0, 0, 2'b00, 1);
    cycle(0, 0, '0, 0, 2'b00, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
